adc_capture_ctrl: RTL

ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

---
 rtl/adc_capture_pkg.sv | 18 +
 rtl/adc_decim_strobe.sv | 27 ++
 rtl/adc_capture_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types for the ADC capture controller: acquisition states and capture modes.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        POST = 2'd2,
        DONE = 2'd3
    } acq_state_t;

    typedef enum logic {
        MODE_ONESHOT = 1'b0,
        MODE_RING    = 1'b1
    } acq_mode_t;

    localparam int DECIM_W = 8;

endpackage

// File: rtl/adc_decim_strobe.sv
// Decimation strobe: passes every (load_val+1)-th valid, starting with the first after clear.
module adc_decim_strobe
    import adc_capture_pkg::*;
(
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               clear,
    input  logic               valid_i,
    input  logic [DECIM_W-1:0] load_val,
    output logic               accept_o
);

    logic [DECIM_W-1:0] cnt;

    always_comb begin
        accept_o = valid_i && (cnt == '0);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || clear) begin
            cnt <= '0;
        end else if (valid_i) begin
            cnt <= accept_o ? load_val : cnt - 1'b1;
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: decimated single-channel capture into RAM, one-shot or ring with trigger.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                NUM_CH    = 2,
    parameter int                ADDR_W    = 13,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 13'h800,
    parameter int                MAX_LEN   = 4096,
    localparam int               CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int               LEN_W     = $clog2(MAX_LEN) + 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [NUM_CH*DATA_W-1:0] adc_sample_in,
    input  logic                     adc_valid_i,
    input  logic                     csr_start_i,
    input  logic                     csr_abort_i,
    input  logic                     csr_mode_i,
    input  logic [CH_W-1:0]          csr_ch_sel_i,
    input  logic [DECIM_W-1:0]       csr_decim_i,
    input  logic [LEN_W-1:0]         csr_len_i,
    input  logic [LEN_W-1:0]         csr_post_len_i,
    input  logic                     trig_i,
    output logic                     csr_busy_o,
    output logic                     csr_done_o,
    output logic [ADDR_W-1:0]        csr_trig_addr_o,
    output logic                     adc_we_o,
    output logic [DATA_W-1:0]        adc_data_o,
    output logic [ADDR_W-1:0]        adc_addr_o
);

    localparam int OFF_W = LEN_W - 1;

    acq_state_t         state, state_n;
    acq_mode_t          mode_q;
    logic [CH_W-1:0]    ch_q;
    logic [DECIM_W-1:0] decim_q;
    logic [LEN_W-1:0]   len_q, post_q, wr_cnt, post_cnt;
    logic [LEN_W-1:0]   len_eff, post_eff;
    logic [OFF_W-1:0]   offset;
    logic               trig_pend;
    logic               active, strobe, accept, start_go, trig_now;
    logic [DATA_W-1:0]  ch_data;

    assign active = (state == RUN) || (state == POST);
    assign accept = strobe && active && !csr_abort_i;

    adc_decim_strobe u_decim (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clear     (start_go || csr_abort_i),
        .valid_i   (adc_valid_i && active),
        .load_val  (decim_q),
        .accept_o  (strobe)
    );

    always_comb begin
        ch_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) ch_data = adc_sample_in[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        len_eff = csr_len_i;
        if (csr_len_i == '0 || csr_len_i > LEN_W'(MAX_LEN)) len_eff = LEN_W'(MAX_LEN);
        post_eff = csr_post_len_i;
        if (csr_post_len_i > LEN_W'(MAX_LEN - 1)) post_eff = LEN_W'(MAX_LEN - 1);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_n;
    end

    // A trigger with no accepted sample is held pending; the next accepted sample becomes the trigger sample.
    always_comb begin
        state_n  = state;
        start_go = 1'b0;
        trig_now = 1'b0;
        if (csr_abort_i) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (csr_start_i) begin
                        state_n  = RUN;
                        start_go = 1'b1;
                    end
                end
                RUN: begin
                    if (mode_q == MODE_ONESHOT) begin
                        if (accept && wr_cnt == len_q - LEN_W'(1)) state_n = DONE;
                    end else if (trig_i) begin
                        trig_now = accept;
                        state_n  = (accept && post_q == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (accept) begin
                        if (trig_pend) begin
                            trig_now = 1'b1;
                            if (post_q == '0) state_n = DONE;
                        end else if (post_cnt == post_q - LEN_W'(1)) begin
                            state_n = DONE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        csr_busy_o = active;
        csr_done_o = (state == DONE);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            mode_q          <= MODE_ONESHOT;
            ch_q            <= '0;
            decim_q         <= '0;
            len_q           <= '0;
            post_q          <= '0;
            wr_cnt          <= '0;
            post_cnt        <= '0;
            offset          <= '0;
            trig_pend       <= 1'b0;
            adc_we_o        <= 1'b0;
            adc_data_o      <= '0;
            adc_addr_o      <= BASE_ADDR;
            csr_trig_addr_o <= BASE_ADDR;
        end else begin
            adc_we_o <= accept;
            if (accept) begin
                adc_data_o <= ch_data;
                adc_addr_o <= BASE_ADDR + ADDR_W'(offset);
                offset     <= offset + 1'b1;
                if (mode_q == MODE_ONESHOT) wr_cnt <= wr_cnt + 1'b1;
                if (state == POST && !trig_pend) post_cnt <= post_cnt + 1'b1;
            end
            if (trig_now) begin
                csr_trig_addr_o <= BASE_ADDR + ADDR_W'(offset);
                trig_pend       <= 1'b0;
            end else if (state == RUN && state_n == POST) begin
                trig_pend <= 1'b1;
            end
            if (start_go) begin
                mode_q    <= acq_mode_t'(csr_mode_i);
                ch_q      <= csr_ch_sel_i;
                decim_q   <= csr_decim_i;
                len_q     <= len_eff;
                post_q    <= post_eff;
                wr_cnt    <= '0;
                post_cnt  <= '0;
                offset    <= '0;
                trig_pend <= 1'b0;
            end
        end
    end

endmodule
